seq_mult_add: RTL

Sequential radix-2 shift-add multiply-accumulator computing product = multiplicand × multiplier + addend, unsigned, one multiplier bit per clock. It is the inverse datapath of the sequential divider and sits beside it in the arithmetic cluster. It recomposes dividend = quotient × divisor + remainder for self-check paths, and serves as a general low-area multiplier. The block uses a single start/busy/dout_vld handshake and holds its result until the next operation.

---
 rtl/seq_mult_add.sv | 122 ++++++++++++
 1 files changed

// File: rtl/seq_mult_add.sv
// seq_mult_add
// Sequential radix-2 shift-add multiply-accumulator:
//   product = multiplicand * multiplier + addend   (unsigned)
// One multiplier bit is consumed per clock. The accumulator starts at the
// addend, so the addition costs no extra cycles.
//
// Handshake: a start seen while busy=0 latches all three operands and raises
// busy on the same edge; start while busy=1 is ignored. On the edge that
// performs the final iteration busy drops, product is loaded and dout_vld
// pulses for exactly one cycle. product then holds until the next completion.
// A new start may be presented while dout_vld=1.
//
// Ports:
//   clk           in   rising-edge clock
//   rst           in   asynchronous active-low reset
//   start         in   operation request, sampled only while idle
//   multiplicand  in   WIDTH  operand A
//   multiplier    in   WIDTH  operand B
//   addend        in   WIDTH  operand C
//   product       out  2*WIDTH  A*B+C, registered
//   busy          out  high while iterating; this is the FSM state (RUN=1)
//   dout_vld      out  one-cycle completion pulse
//
// Optional feature macro: SEQ_MULT_ADD_EARLY_TERM_EN
//   When defined, the operation finishes as soon as the remaining multiplier
//   bits are all zero, and the partial result is re-aligned with a variable
//   right shift. Results are identical; only latency changes.
//   When undefined, every operation takes exactly WIDTH iterations.

module seq_mult_add #(
  parameter int WIDTH = 32,
  parameter int CBIT  = 5
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [WIDTH-1:0]   multiplicand,
  input  logic [WIDTH-1:0]   multiplier,
  input  logic [WIDTH-1:0]   addend,
  output logic [2*WIDTH-1:0] product,
  output logic               busy,
  output logic               dout_vld
);

  // FSM encoding; the state register drives busy directly.
  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_RUN  = 1'b1;

  logic [0:0]         r_state;
  logic [WIDTH-1:0]   r_mcand;
  logic [WIDTH-1:0]   r_acc_hi;
  logic [WIDTH-1:0]   r_acc_lo;
  logic [CBIT-1:0]    r_cnt;
  logic [2*WIDTH-1:0] r_product;
  logic               r_dout_vld;

  logic [WIDTH:0]     w_sum;
  logic [2*WIDTH-1:0] w_next_acc;
  logic               w_last;
  logic [2*WIDTH-1:0] w_result;

  // One shift-add step. The carry sum[WIDTH] lands in the top bit of acc_hi
  // because the whole pair shifts right by one as the sum is written back.
  assign w_sum      = {1'b0, r_acc_hi} + {1'b0, (r_acc_lo[0] ? r_mcand : {WIDTH{1'b0}})};
  assign w_next_acc = {w_sum, r_acc_lo[WIDTH-1:1]};

`ifdef SEQ_MULT_ADD_EARLY_TERM_EN
  // Before iteration cnt, acc_lo[WIDTH-1-cnt:0] still holds multiplier bits
  // cnt..WIDTH-1. Bit 0 is consumed now, so the bits left for later
  // iterations are acc_lo[WIDTH-1-cnt:1], i.e. the low WIDTH-1-cnt bits of
  // acc_lo[WIDTH-1:1]. If they are all zero the remaining iterations would
  // only shift, so the shift is applied in one go instead.
  logic [WIDTH-2:0] w_rem_mask;
  assign w_rem_mask = {(WIDTH-1){1'b1}} >> r_cnt;
  assign w_last     = ((r_acc_lo[WIDTH-1:1] & w_rem_mask) == '0);
  assign w_result   = w_next_acc >> (CBIT'(WIDTH-1) - r_cnt);
`else
  assign w_last     = (r_cnt == CBIT'(WIDTH-1));
  assign w_result   = w_next_acc;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state    <= S_IDLE;
      r_mcand    <= '0;
      r_acc_hi   <= '0;
      r_acc_lo   <= '0;
      r_cnt      <= '0;
      r_product  <= '0;
      r_dout_vld <= 1'b0;
    end else begin
      r_dout_vld <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_mcand  <= multiplicand;
            r_acc_hi <= addend;
            r_acc_lo <= multiplier;
            r_cnt    <= '0;
            r_state  <= S_RUN;
          end
        end
        S_RUN: begin
          r_acc_hi <= w_next_acc[2*WIDTH-1:WIDTH];
          r_acc_lo <= w_next_acc[WIDTH-1:0];
          r_cnt    <= r_cnt + 1'b1;
          if (w_last) begin
            r_product  <= w_result;
            r_dout_vld <= 1'b1;
            r_state    <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign product  = r_product;
  assign busy     = r_state;
  assign dout_vld = r_dout_vld;

endmodule
